// File: rtl/ecpa_pkg.sv
// Shared width and FSM encoding for the modular-multiplier arbiter slice.
package ecpa_pkg;
    localparam int W = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2
    } state_t;
endpackage

// File: rtl/mm_arbiter_if.sv
// Requester and multiplier signals of mm_arbiter; slave is the arbiter's view.
interface mm_arbiter_if #(parameter int W = ecpa_pkg::W);
    logic         req0;
    logic         req1;
    logic [W-1:0] a0;
    logic [W-1:0] b0;
    logic [W-1:0] m0;
    logic [W-1:0] a1;
    logic [W-1:0] b1;
    logic [W-1:0] m1;
    logic         done0;
    logic         done1;
    logic [W-1:0] p_out;
    logic         busy;
    logic         mm_start;
    logic [W-1:0] mm_a;
    logic [W-1:0] mm_b;
    logic [W-1:0] mm_m;
    logic [W-1:0] mm_p;
    logic         mm_ready;

    modport slave (
        input  req0, req1, a0, b0, m0, a1, b1, m1, mm_p, mm_ready,
        output done0, done1, p_out, busy, mm_start, mm_a, mm_b, mm_m
    );

    modport master (
        output req0, req1, a0, b0, m0, a1, b1, m1, mm_p, mm_ready,
        input  done0, done1, p_out, busy, mm_start, mm_a, mm_b, mm_m
    );
endinterface

// File: rtl/mm_rr_arb2.sv
// Two-way round-robin pick, purely combinational (zero latency, no backpressure);
// on a tie the requester not granted last wins.
module mm_rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic gnt_valid,
    output logic gnt_id
);
    assign gnt_valid = req0 | req1;
    assign gnt_id    = (req0 & req1) ? ~last : req1;
endmodule

// File: rtl/mm_arbiter.sv
// Shares one modular multiplier between two requesters; start follows grant by 1 cycle,
// requesters wait (req held) until their done pulse, multiplier paced by mm_ready.
module mm_arbiter #(
    parameter int W = ecpa_pkg::W
) (
    input logic        clk,
    input logic        rst_n,
    mm_arbiter_if.slave bus
);
    import ecpa_pkg::state_t;
    import ecpa_pkg::IDLE;
    import ecpa_pkg::ISSUE;
    import ecpa_pkg::RELEASE;

    state_t       state_q;
    state_t       state_d;
    logic         gnt_valid;
    logic         gnt_id;
    logic         gnt_q;
    logic         last_q;
    logic         done0_q;
    logic         done1_q;
    logic         mm_start;
    logic         busy;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic [W-1:0] m_q;
    logic [W-1:0] p_q;

    mm_rr_arb2 u_rr (
        .req0      (bus.req0),
        .req1      (bus.req1),
        .last      (last_q),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (gnt_valid)     state_d = ISSUE;
            ISSUE:   if (bus.mm_ready)  state_d = RELEASE;
            RELEASE: if (!bus.mm_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    always_comb begin
        mm_start = (state_q == ISSUE);
        busy     = (state_q != IDLE);
    end

    // Operands are frozen at grant so req/operand changes in flight are invisible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            p_q     <= '0;
        end else begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            if (state_q == IDLE && gnt_valid) begin
                gnt_q <= gnt_id;
                a_q   <= gnt_id ? bus.a1 : bus.a0;
                b_q   <= gnt_id ? bus.b1 : bus.b0;
                m_q   <= gnt_id ? bus.m1 : bus.m0;
            end
            if (state_q == ISSUE && bus.mm_ready) begin
                p_q     <= bus.mm_p;
                last_q  <= gnt_q;
                done0_q <= ~gnt_q;
                done1_q <= gnt_q;
            end
        end
    end

    assign bus.done0    = done0_q;
    assign bus.done1    = done1_q;
    assign bus.p_out    = p_q;
    assign bus.busy     = busy;
    assign bus.mm_start = mm_start;
    assign bus.mm_a     = a_q;
    assign bus.mm_b     = b_q;
    assign bus.mm_m     = m_q;
endmodule

// File: tb/tb_mm_arbiter.sv
// Directed bench for mm_arbiter with a behavioural modular multiplier (3-cycle latency,
// mm_ready held two cycles past start).
module tb_mm_arbiter;
    localparam int W = 256;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mm_arbiter_if #(.W(W)) bus ();

    mm_arbiter #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic         model_ready = 1'b0;
    logic         ready_force = 1'b0;
    logic [W-1:0] mm_p_drv    = '0;
    int           m_cnt = 0;
    int           r_cnt = 0;
    logic [2*W-1:0] prod;

    assign bus.mm_ready = model_ready | ready_force;
    assign bus.mm_p     = mm_p_drv;

    always @(negedge clk) begin
        if (!rst_n) begin
            model_ready = 1'b0;
            m_cnt = 0;
            r_cnt = 0;
        end else if (bus.mm_start) begin
            r_cnt = 0;
            if (!model_ready) begin
                if (m_cnt == 2) begin
                    prod = {{W{1'b0}}, bus.mm_a} * {{W{1'b0}}, bus.mm_b};
                    prod = prod % {{W{1'b0}}, bus.mm_m};
                    mm_p_drv = prod[W-1:0];
                    model_ready = 1'b1;
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
        end else begin
            m_cnt = 0;
            if (model_ready) begin
                if (r_cnt == 1) begin
                    model_ready = 1'b0;
                    r_cnt = 0;
                end else begin
                    r_cnt++;
                end
            end
        end
    end

    int n_done0 = 0;
    int n_done1 = 0;
    int n_both  = 0;
    int n_wide  = 0;
    int n_ord   = 0;
    int order [32];
    logic prev0 = 1'b0;
    logic prev1 = 1'b0;

    always @(negedge clk) begin
        if (bus.done0 && bus.done1) n_both++;
        if ((bus.done0 && prev0) || (bus.done1 && prev1)) n_wide++;
        if (bus.done0) begin
            n_done0++;
            if (n_ord < 32) order[n_ord] = 0;
            n_ord++;
        end
        if (bus.done1) begin
            n_done1++;
            if (n_ord < 32) order[n_ord] = 1;
            n_ord++;
        end
        prev0 = bus.done0;
        prev1 = bus.done1;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input bit id, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if ((!id && bus.done0) || (id && bus.done1)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_any(output bit id, output bit ok);
        ok = 1'b0;
        id = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done0 || bus.done1) begin
                ok = 1'b1;
                id = bus.done1;
                break;
            end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic serve(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] m, input logic [W-1:0] exp_p, input string tag);
        bit ok;
        if (id) begin
            bus.a1 = a; bus.b1 = b; bus.m1 = m; bus.req1 = 1'b1;
        end else begin
            bus.a0 = a; bus.b0 = b; bus.m0 = m; bus.req0 = 1'b1;
        end
        tick();
        chk({tag, "_start_lat1"}, bus.mm_start, 1);
        chk({tag, "_busy"}, bus.busy, 1);
        chk({tag, "_mm_a"}, bus.mm_a, a);
        chk({tag, "_mm_b"}, bus.mm_b, b);
        chk({tag, "_mm_m"}, bus.mm_m, m);
        wait_done(id, ok);
        chk({tag, "_done_seen"}, ok, 1);
        if (id) bus.req1 = 1'b0;
        else    bus.req0 = 1'b0;
        chk({tag, "_p_out"}, bus.p_out, exp_p);
        chk({tag, "_other_done"}, id ? bus.done0 : bus.done1, 0);
        chk({tag, "_start_clr"}, bus.mm_start, 0);
        wait_idle(ok);
        chk({tag, "_idle"}, ok, 1);
    endtask

    logic [W-1:0]   big_a;
    logic [W-1:0]   big_b;
    logic [W-1:0]   big_m;
    logic [W-1:0]   big_ref;
    logic [2*W-1:0] wide;
    int             d0;
    int             d1;
    int             base;
    bit             ok;
    bit             id;

    initial begin
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.a0 = '0; bus.b0 = '0; bus.m0 = '0;
        bus.a1 = '0; bus.b1 = '0; bus.m1 = '0;

        tick();
        chk("rst_busy", bus.busy, 0);
        chk("rst_start", bus.mm_start, 0);
        chk("rst_done0", bus.done0, 0);
        chk("rst_done1", bus.done1, 0);
        chk("rst_p_out", bus.p_out, 0);
        chk("rst_mm_a", bus.mm_a, 0);
        chk("rst_mm_m", bus.mm_m, 0);
        rst_n = 1'b1;
        tick();

        // Stray mm_ready in IDLE must not complete anything.
        ready_force = 1'b1;
        mm_p_drv    = 'h55;
        tick(); tick(); tick();
        chk("idle_ready_busy", bus.busy, 0);
        chk("idle_ready_dones", n_done0 + n_done1, 0);
        chk("idle_ready_p_out", bus.p_out, 0);
        ready_force = 1'b0;
        tick();

        serve(1'b0, 1, 1, 23, 1, "t1");
        chk("t1_done0_cnt", n_done0, 1);
        chk("t1_done1_cnt", n_done1, 0);

        serve(1'b1, 3, 4, 5, 2, "t2");
        chk("t2_done1_cnt", n_done1, 1);
        chk("t2_done0_cnt", n_done0, 1);

        // Simultaneous requests straight after reset: requester 0 wins the first tie.
        do_reset();
        base = n_ord;
        bus.a0 = 1; bus.b0 = 1; bus.m0 = 23;
        bus.a1 = 3; bus.b1 = 4; bus.m1 = 5;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        tick();
        chk("t3_first_mm_a", bus.mm_a, 1);
        chk("t3_first_mm_m", bus.mm_m, 23);
        wait_done(1'b0, ok);
        chk("t3_done0_seen", ok, 1);
        bus.req0 = 1'b0;
        chk("t3_p_out0", bus.p_out, 1);
        chk("t3_gap_start", bus.mm_start, 0);
        wait_done(1'b1, ok);
        chk("t3_done1_seen", ok, 1);
        bus.req1 = 1'b0;
        chk("t3_p_out1", bus.p_out, 2);
        chk("t3_order0", order[base], 0);
        chk("t3_order1", order[base + 1], 1);
        wait_idle(ok);
        chk("t3_idle", ok, 1);

        // Both held high: completions alternate 0,1,0,1.
        bus.a0 = 2; bus.b0 = 3; bus.m0 = 7;
        bus.a1 = 5; bus.b1 = 5; bus.m1 = 11;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_any(id, ok);
            chk("t4_done_seen", ok, 1);
            chk("t4_grant_id", id, i % 2);
            chk("t4_p_out", bus.p_out, (i % 2) ? 3 : 6);
            if (i == 3) begin
                bus.req0 = 1'b0;
                bus.req1 = 1'b0;
            end
        end
        wait_idle(ok);
        chk("t4_idle", ok, 1);

        // Full-width operands; a0 disturbed mid-ISSUE.
        big_a = 256'hE5A3B45D7F29DCE6E89E3F08A7F68DAE8B771B75D7422F9A63FA9D423D51D6E9;
        big_b = 256'hF7E75FDC469067FFDC439B16B7D2F0FBA2F3B5A6ABF5A7E7CE0F05EDDA3C339B;
        big_m = ~256'd188;
        wide = ({{W{1'b0}}, big_a} * {{W{1'b0}}, big_b}) % {{W{1'b0}}, big_m};
        big_ref = wide[W-1:0];
        bus.a0 = big_a; bus.b0 = big_b; bus.m0 = big_m;
        bus.req0 = 1'b1;
        tick();
        chk("t5_mm_a", bus.mm_a, big_a);
        bus.a0 = 'h1234;
        tick();
        chk("t5_mm_a_held", bus.mm_a, big_a);
        chk("t5_start_held", bus.mm_start, 1);
        wait_done(1'b0, ok);
        chk("t5_done_seen", ok, 1);
        bus.req0 = 1'b0;
        chk("t5_p_out", bus.p_out, big_ref);
        wait_idle(ok);
        chk("t5_idle", ok, 1);

        // Reset mid-ISSUE aborts without a done pulse.
        d0 = n_done0;
        d1 = n_done1;
        bus.a0 = 1; bus.b0 = 1; bus.m0 = 23;
        bus.req0 = 1'b1;
        tick();
        chk("t6_start", bus.mm_start, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_start", bus.mm_start, 0);
        chk("t6_rst_busy", bus.busy, 0);
        chk("t6_rst_done0", bus.done0, 0);
        chk("t6_rst_done1", bus.done1, 0);
        chk("t6_rst_mm_a", bus.mm_a, 0);
        chk("t6_rst_mm_m", bus.mm_m, 0);
        chk("t6_rst_p_out", bus.p_out, 0);
        bus.req0 = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("t6_no_done", n_done0, d0);
        chk("t6_idle_after", bus.busy, 0);
        serve(1'b1, 3, 4, 5, 2, "t6_req1");
        chk("t6_done1_cnt", n_done1, d1 + 1);
        chk("t6_done0_cnt", n_done0, d0);

        chk("never_both_done", n_both, 0);
        chk("done_one_cycle", n_wide, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mm_arbiter.md
MM_ARBITER -- requirements
Module: mm_arbiter

Interface
REQ-001 Parameter W, default 256, operand/result width in bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 req0, req1  input  1 each  requester k asks for one modular multiplication; held high until done_k.
REQ-005 a0, b0, m0, a1, b1, m1  input  W each  operands of requester k; valid while req_k is high.
REQ-006 done0, done1  output  1 each  one-cycle pulse; result for requester k is on p_out.
REQ-007 p_out  output  W  last result, (a*b) mod m, held until the next completion.
REQ-008 busy  output  1  high in every state other than IDLE.
REQ-009 mm_start  output  1  start to the shared modular_multiplication.
REQ-010 mm_a, mm_b, mm_m  output  W each  registered operands to the multiplier.
REQ-011 mm_p  input  W  multiplier result; valid while mm_ready is high.
REQ-012 mm_ready  input  1  multiplier completion flag.

Function
REQ-013 States SHALL be IDLE, ISSUE and RELEASE.
REQ-014 IDLE with no req SHALL stay in IDLE, with mm_start=0.
REQ-015 IDLE with exactly one req_k high SHALL grant k, latch a_k/b_k/m_k into mm_a/mm_b/mm_m, and go to ISSUE.
REQ-016 IDLE with both req high SHALL grant the requester not granted last (round-robin); after reset the first tie goes to requester 0.
REQ-017 ISSUE SHALL drive mm_start=1 and hold mm_a/mm_b/mm_m stable until mm_ready is sampled high.
REQ-018 The first ISSUE cycle SHALL be the cycle after the grant edge; grant-to-start latency is 1 cycle.
REQ-019 mm_ready sampled high in ISSUE SHALL, at that edge: capture mm_p into p_out, pulse done_k for exactly one cycle, clear mm_start, go to RELEASE, and record k as last granted.
REQ-020 RELEASE SHALL hold mm_start=0 while mm_ready=1, and go to IDLE on the first cycle mm_ready=0; RELEASE lasts at least one cycle.
REQ-021 A requester whose req is still high in IDLE after its done SHALL be treated as a new request, subject to REQ-016.
REQ-022 A req change during ISSUE or RELEASE SHALL NOT affect the operation in flight; only the values latched at grant are used.
REQ-023 done0 and done1 SHALL never be high in the same cycle.
REQ-024 mm_ready high while in IDLE SHALL be ignored and SHALL NOT produce done.
REQ-025 p_out SHALL be exactly W bits; no reduction or extension is done in the arbiter.

Reset
REQ-026 rst_n low SHALL immediately force: state=IDLE; mm_start, done0, done1 and busy = 0; mm_a/mm_b/mm_m/p_out = 0; last-granted = 1 (so requester 0 wins the first tie).
REQ-027 Reset during ISSUE or RELEASE SHALL abort the operation with no done pulse; the multiplier shares rst_n.
REQ-028 After rst_n deasserts, the first grant SHALL occur on the first clk edge with a req high.

Structure
REQ-029 W and the state enum SHALL live in shared package ecpa_pkg.
REQ-030 The round-robin pick SHALL be sub-module mm_rr_arb2 (inputs req0, req1, last; outputs gnt_valid, gnt_id), combinational.
REQ-031 The modular_multiplication instance SHALL sit outside mm_arbiter and connect through the mm_* ports.

Verification
REQ-032 req0 only, a=1 b=1 m=23 -> mm_start the cycle after grant; done0 once; p_out=1; done1 never.
REQ-033 req1 only, a=3 b=4 m=5 -> done1 once; p_out=2.
REQ-034 req0 and req1 raised in the same cycle after reset, operands (1,1,23) and (3,4,5) -> requester 0 served first (p_out=1), then requester 1 (p_out=2); mm_start low for at least one cycle between the two.
REQ-035 Both req held high continuously -> grants alternate 0,1,0,1 over 4 completions.
REQ-036 req0 with a=E5A3B45D7F29DCE6E89E3F08A7F68DAE8B771B75D7422F9A63FA9D423D51D6E9, b=F7E75FDC469067FFDC439B16B7D2F0FBA2F3B5A6ABF5A7E7CE0F05EDDA3C339B, m=2^256-189 -> p_out matches the bench's (a*b) mod m reference; a0 changed mid-ISSUE has no effect on the result.
REQ-037 rst_n pulled low mid-ISSUE -> all outputs 0 at once; no done pulse; a fresh req1 after release is served normally.
